imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Writes a program image into the CPU's instruction memory; the CPU only ever reads that memory.
//  Accepts a byte stream (e.g. from a UART receiver) and packs it into 32-bit words.
//  Each word is committed through a single write port.
//  Holds the CPU in reset until a complete, checksum-verified image is loaded.
// PARAMETERS
//  ADDR_W       8          word-address width of the instruction-memory write port
//  MAX_WORDS    256        largest accepted image, in words (must be <= 2**ADDR_W)
//  TIMEOUT_CYC  1000000    idle cycles between bytes before a load is aborted
// PORTS
//  clk         in   1       system clock, rising edge
//  rst_n       in   1       asynchronous, active-low reset
//  rx_data     in   8       received byte
//  rx_valid    in   1       1-cycle strobe: rx_data is valid; back-to-back strobes allowed
//  imem_we     out  1       1-cycle instruction-memory write strobe
//  imem_addr   out  ADDR_W  word address for the write (byte address = imem_addr<<2)
//  imem_wdata  out  32      instruction word
//  cpu_rst     out  1       active-high reset to the CPU core; 1 = CPU held
//  busy        out  1       1 while in LEN_HI, LEN_LO, DATA or CHK
//  done        out  1       1 in DONE state
//  error       out  1       1 in ERR state
// BEHAVIOUR
//  Reset: state=IDLE, cpu_rst=1, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, error=0.
//    Reset mid-load abandons the load; already-written words are not cleared.
//  Frame format: SYNC(0xA5), LEN_HI, LEN_LO, then N*4 data bytes, then CHK.
//    N = {LEN_HI,LEN_LO}. Words are big-endian: the first data byte goes to wdata[31:24].
//    CHK = XOR of all data bytes.
//  State machine:
//  - IDLE: non-SYNC bytes are ignored. SYNC -> LEN_HI.
//  - LEN_HI -> LEN_LO on a byte.
//  - LEN_LO on a byte: N==0 or N>MAX_WORDS -> ERR; otherwise -> DATA with word index=0 and xor=0.
//  - DATA: every byte updates xor and shifts into the packer.
//    After the 4th byte of a word, imem_we=1 on the next cycle (1-cycle latency, registered),
//    with imem_addr=word index and imem_wdata=packed word. Then the index increments.
//    The 4th byte of word N-1 -> CHK.
//  - CHK: byte==xor -> DONE; otherwise -> ERR.
//  - DONE: cpu_rst=0, done=1. A SYNC byte restarts the load: cpu_rst=1 and done=0 on the next cycle.
//    Non-SYNC bytes are ignored.
//  - ERR: cpu_rst=1, error=1. A SYNC byte restarts the load; non-SYNC bytes are ignored.
//  cpu_rst=1 in every state except DONE. A SYNC byte is treated as data in every state other
//    than IDLE, DONE and ERR.
//  Timeout: the counter runs only in LEN_HI, LEN_LO, DATA and CHK, and clears on each rx_valid.
//    Reaching TIMEOUT_CYC-1 with no byte -> ERR.
//    If rx_valid arrives in the same cycle as expiry, the byte is accepted and no error occurs.
//  Widths: the word index counts modulo 2**ADDR_W. Exceeding MAX_WORDS is impossible because
//    N is checked in LEN_LO. The xor is 8 bits.
//  No imem_we is issued outside DATA. A partially packed word is never written.
// STRUCTURE
//  Package imem_loader_pkg holds: the state encoding (IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR),
//    SYNC_BYTE=8'hA5, and BYTES_PER_WORD=4.
//  One sub-module, rx_timeout: a loadable down-counter with inputs clear/enable and a 1-cycle
//    expire output.
//  Packer, byte counter, word index, xor and FSM all live in imem_loader.
// TESTING
//  1. Reset, then 0xA5,00,02, DE AD BE EF, 00 00 00 08, CHK=0x08^0xDE^0xAD^0xBE^0xEF
//     -> two writes: addr0=DEADBEEF, addr1=00000008. Then done=1 and cpu_rst=0.
//  2. Bytes 0x11,0x22 before 0xA5 -> ignored; no imem_we; cpu_rst stays 1.
//  3. LEN=0x0000, and separately LEN=MAX_WORDS+1 -> ERR, error=1, no writes. A following
//     valid frame -> DONE.
//  4. Valid frame with a wrong CHK -> error=1, cpu_rst=1; both words were still written.
//  5. Stall of TIMEOUT_CYC cycles after the 2nd data byte -> ERR. Separately, a byte arriving
//     exactly on the expiry cycle -> no error.
//  6. From DONE, send 0xA5 -> cpu_rst=1 the next cycle. Also assert rst_n mid-DATA ->
//     all outputs at reset values immediately.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and framing constants for the instruction-memory loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam logic [7:0] SYNC_BYTE      = 8'hA5;
    localparam int         BYTES_PER_WORD = 4;

    // States in which a frame is in flight and the inter-byte timeout applies.
    function automatic logic is_busy(input state_e s);
        return s inside {ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CHK};
    endfunction

endpackage

// File: rtl/imem_loader_rx_timeout.sv
// rx_timeout: loadable down-counter flagging a gap of CYCLES cycles between received bytes
//   clk, rst_n  clock, asynchronous active-low reset
//   clear_i     reload the counter (a byte arrived)
//   enable_i    count only while asserted; reloads otherwise
//   expire_o    1-cycle strobe on the last idle cycle; suppressed when clear_i is high
module rx_timeout #(
    parameter int CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int             CW   = CYCLES > 1 ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0]  LOAD = CW'(CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= LOAD;
        else if (clear_i || !enable_i)
            cnt_q <= LOAD;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    // A byte on the expiry cycle wins: the clear masks the strobe.
    assign expire_o = enable_i && !clear_i && (cnt_q == '0);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream, writes it into instruction memory and releases the CPU
//   clk, rst_n   clock, asynchronous active-low reset
//   rx_data      received byte, qualified by rx_valid (1-cycle strobe)
//   imem_we      1-cycle write strobe with imem_addr (word address) and imem_wdata
//   cpu_rst      holds the CPU in reset until a checksum-verified image is loaded
//   busy/done/error  frame in progress / image loaded / load failed
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int MAX_WORDS   = 256,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int BW = $clog2(BYTES_PER_WORD);
    localparam int PW = 8 * (BYTES_PER_WORD - 1);

    state_e            state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [15:0]       rem_q, rem_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic [7:0]        xor_q, xor_d;
    logic [PW-1:0]     pack_q, pack_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              busy_q, done_q, error_q, cpu_rst_q;
    logic [15:0]       n;
    logic              expire;

    rx_timeout #(.CYCLES(TIMEOUT_CYC)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (rx_valid),
        .enable_i(is_busy(state_q)),
        .expire_o(expire)
    );

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        rem_d    = rem_q;
        idx_d    = idx_q;
        bcnt_d   = bcnt_q;
        xor_d    = xor_q;
        pack_d   = pack_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        n        = {len_hi_q, rx_data};
        if (rx_valid) begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR:
                    state_d = (rx_data == SYNC_BYTE) ? ST_LEN_HI : state_q;
                ST_LEN_HI: begin
                    len_hi_d = rx_data;
                    state_d  = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    state_d = (n == '0 || 32'(n) > MAX_WORDS) ? ST_ERR : ST_DATA;
                    rem_d   = n - 16'd1;
                    idx_d   = '0;
                    bcnt_d  = '0;
                    xor_d   = '0;
                end
                ST_DATA: begin
                    xor_d  = xor_q ^ rx_data;
                    pack_d = {pack_q[PW-9:0], rx_data};
                    bcnt_d = bcnt_q + 1'b1;
                    // Last byte of a word: commit it; rem_q counts words still to come after this one.
                    if (bcnt_q == BW'(BYTES_PER_WORD - 1)) begin
                        we_d    = 1'b1;
                        addr_d  = idx_q;
                        wdata_d = {pack_q, rx_data};
                        idx_d   = idx_q + 1'b1;
                        rem_d   = rem_q - 16'd1;
                        state_d = (rem_q == '0) ? ST_CHK : ST_DATA;
                    end
                end
                ST_CHK:
                    state_d = (rx_data == xor_q) ? ST_DONE : ST_ERR;
                default:
                    state_d = ST_ERR;
            endcase
        end else if (expire) begin
            state_d = ST_ERR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            len_hi_q  <= '0;
            rem_q     <= '0;
            idx_q     <= '0;
            bcnt_q    <= '0;
            xor_q     <= '0;
            pack_q    <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            len_hi_q  <= len_hi_d;
            rem_q     <= rem_d;
            idx_q     <= idx_d;
            bcnt_q    <= bcnt_d;
            xor_q     <= xor_d;
            pack_q    <= pack_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            busy_q    <= is_busy(state_d);
            done_q    <= (state_d == ST_DONE);
            error_q   <= (state_d == ST_ERR);
            cpu_rst_q <= (state_d != ST_DONE);
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_rst    = cpu_rst_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule
